// File: rtl/direction_queue.sv
// direction_queue: buffers direction button presses between the push buttons and the
// snake body controller. Every rising edge of a button becomes one candidate turn, so
// several quick turns inside one movement step are applied on successive steps.
// Each step pulse releases one queued turn onto the registered dir output.
// Compile-time option: define DIRQ_REVERSE_FILTER_EN to also discard 180-degree reversals.
// Direction encoding: 00 up, 01 down, 10 left, 11 right.
module direction_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         nrst,
  input  logic [3:0]                   direction_pb,
  input  logic                         step,
  input  logic                         sync,
  output logic [1:0]                   dir,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full,
  output logic                         dropped
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(DEPTH - 1);
  localparam logic [1:0] DirRight = 2'b11;

  logic [3:0]      pb_meta_q, pb_sync_q, pb_prev_q;
  logic [3:0]      pb_rise;
  logic [1:0]      mem_q [DEPTH];
  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q, tail_ptr;
  logic [CntW-1:0] count_q;
  logic [1:0]      dir_q;
  logic            dropped_q;
  logic            cand_valid, cand_ok;
  logic [1:0]      cand_dir, ref_dir;
  logic            do_push, do_pop, do_drop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrLast) ? '0 : p + PtrW'(1);
  endfunction

  // Two-flop synchronizer plus edge history; sync deliberately leaves these alone so a
  // button held across a restart does not produce a new candidate.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pb_meta_q <= '0;
      pb_sync_q <= '0;
      pb_prev_q <= '0;
    end else begin
      pb_meta_q <= direction_pb;
      pb_sync_q <= pb_meta_q;
      pb_prev_q <= pb_sync_q;
    end
  end

  assign pb_rise = pb_sync_q & ~pb_prev_q;

  // Pick a single candidate per cycle: up > down > left > right.
  always_comb begin
    cand_valid = 1'b1;
    cand_dir   = 2'b00;
    if (pb_rise[3])      cand_dir = 2'b00;
    else if (pb_rise[2]) cand_dir = 2'b01;
    else if (pb_rise[1]) cand_dir = 2'b10;
    else if (pb_rise[0]) cand_dir = 2'b11;
    else                 cand_valid = 1'b0;
  end

  // Reference is the most recently queued turn, or the live direction if none queued.
  assign tail_ptr = (wr_ptr_q == '0) ? PtrLast : wr_ptr_q - PtrW'(1);
  assign ref_dir  = (count_q != '0) ? mem_q[tail_ptr] : dir_q;

`ifdef DIRQ_REVERSE_FILTER_EN
  assign cand_ok = cand_valid && (cand_dir != ref_dir) && (cand_dir != (ref_dir ^ 2'b01));
`else
  assign cand_ok = cand_valid && (cand_dir != ref_dir);
`endif

  // A pop in the same cycle frees a slot, so a full queue still accepts the push.
  assign do_pop  = step && (count_q != '0);
  assign do_push = cand_ok && ((count_q != CntFull) || do_pop);
  assign do_drop = cand_ok && (count_q == CntFull) && !do_pop;

  // Circular buffer, current direction and drop flag; sync overrides step and push.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= 2'b00;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      dir_q     <= DirRight;
      dropped_q <= 1'b0;
    end else if (sync) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      dir_q     <= DirRight;
      dropped_q <= 1'b0;
    end else begin
      dropped_q <= do_drop;
      if (do_push) begin
        mem_q[wr_ptr_q] <= cand_dir;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        dir_q    <= mem_q[rd_ptr_q];
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      if (do_push && !do_pop)      count_q <= count_q + CntW'(1);
      else if (do_pop && !do_push) count_q <= count_q - CntW'(1);
    end
  end

  assign dir     = dir_q;
  assign count   = count_q;
  assign empty   = (count_q == '0);
  assign full    = (count_q == CntFull);
  assign dropped = dropped_q;

endmodule

// File: tb/tb_direction_queue.sv
// Self-checking bench for direction_queue: a queue-based reference model checked every
// cycle, plus literal expectations from hand-worked press/step sequences.
module tb_direction_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CntW  = $clog2(DEPTH + 1);

  logic            clk = 1'b0;
  logic            nrst = 1'b0;
  logic [3:0]      direction_pb = 4'b0000;
  logic            step = 1'b0;
  logic            sync = 1'b0;
  logic [1:0]      dir;
  logic [CntW-1:0] count;
  logic            empty, full, dropped;

  int errors = 0;
  int checks = 0;

  direction_queue #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .nrst         (nrst),
    .direction_pb (direction_pb),
    .step         (step),
    .sync         (sync),
    .dir          (dir),
    .count        (count),
    .empty        (empty),
    .full         (full),
    .dropped      (dropped)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: button values sampled at the last three edges, plus a plain queue.
  logic [3:0] p1, p2, p3;
  logic [1:0] m_q[$];
  logic [1:0] m_dir;
  logic       m_drop;

  always @(posedge clk or negedge nrst) begin
    logic [3:0] rise;
    logic [1:0] cand, rdir, head;
    logic       cv, ok, pop;
    if (!nrst) begin
      p1 = 4'b0; p2 = 4'b0; p3 = 4'b0;
      m_q.delete();
      m_dir = 2'b11;
      m_drop = 1'b0;
    end else begin
      // A press seen at edge n-2 that was absent at edge n-3 is detected now.
      rise = p2 & ~p3;
      p3 = p2; p2 = p1; p1 = direction_pb;
      cv = 1'b1;
      if (rise[3])      cand = 2'd0;
      else if (rise[2]) cand = 2'd1;
      else if (rise[1]) cand = 2'd2;
      else if (rise[0]) cand = 2'd3;
      else begin cand = 2'd0; cv = 1'b0; end
      if (sync) begin
        m_q.delete();
        m_dir = 2'b11;
        m_drop = 1'b0;
      end else begin
        rdir = (m_q.size() > 0) ? m_q[m_q.size()-1] : m_dir;
        ok = cv && (cand != rdir);
`ifdef DIRQ_REVERSE_FILTER_EN
        ok = ok && (cand != (rdir ^ 2'b01));
`endif
        pop = step && (m_q.size() > 0);
        m_drop = 1'b0;
        if (pop) begin
          head = m_q.pop_front();
          m_dir = head;
        end
        if (ok) begin
          if (m_q.size() < DEPTH) m_q.push_back(cand);
          else m_drop = 1'b1;
        end
      end
    end
  end

  // Compare every cycle, half a period away from the active edge.
  always @(negedge clk) begin
    chk("dir", int'(dir), int'(m_dir));
    chk("count", int'(count), m_q.size());
    chk("empty", int'(empty), int'(m_q.size() == 0));
    chk("full", int'(full), int'(m_q.size() == DEPTH));
    chk("dropped", int'(dropped), int'(m_drop));
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle press, then wait until the resulting push is visible.
  task automatic press(input logic [3:0] bits);
    direction_pb = bits;
    tick();
    direction_pb = 4'b0000;
    tick(2);
  endtask

  task automatic do_step();
    step = 1'b1;
    tick();
    step = 1'b0;
  endtask

  task automatic do_sync();
    sync = 1'b1;
    tick();
    sync = 1'b0;
  endtask

  initial begin
    tick(2);
    chk("reset_dir", int'(dir), 3);
    chk("reset_count", int'(count), 0);
    chk("reset_empty", int'(empty), 1);
    nrst = 1'b1;
    tick();

    // Up press: count becomes 1 after three edges; step applies it.
    direction_pb = 4'b1000;
    tick(2);
    chk("up_latency_early", int'(count), 0);
    tick();
    chk("up_pushed", int'(count), 1);
    direction_pb = 4'b0000;
    tick();
    do_step();
    chk("up_dir", int'(dir), 0);
    chk("up_popped", int'(count), 0);

    // Three quick turns, then three steps.
    do_sync();
    chk("sync_dir", int'(dir), 3);
    press(4'b1000);
    press(4'b0010);
    press(4'b0100);
    chk("three_count", int'(count), 3);
    do_step();
    chk("seq_dir0", int'(dir), 0);
    do_step();
    chk("seq_dir1", int'(dir), 2);
    do_step();
    chk("seq_dir2", int'(dir), 1);
    chk("seq_empty", int'(empty), 1);
    do_step();
    chk("step_empty_hold", int'(dir), 1);

    // Reversal and redundant-turn filtering from dir = right.
    do_sync();
    press(4'b0010);
`ifdef DIRQ_REVERSE_FILTER_EN
    chk("reverse_filtered", int'(count), 0);
`else
    chk("reverse_queued", int'(count), 1);
`endif
    chk("reverse_no_drop", int'(dropped), 0);
    do_sync();
    press(4'b0001);
    chk("same_dir_filtered", int'(count), 0);

    // Fill to DEPTH, then overflow.
    do_sync();
    press(4'b1000);
    press(4'b0010);
    press(4'b1000);
    press(4'b0010);
    chk("fill_count", int'(count), 4);
    chk("fill_full", int'(full), 1);
    press(4'b0100);
    chk("overflow_drop", int'(dropped), 1);
    chk("overflow_count", int'(count), 4);
    tick();
    chk("drop_one_cycle", int'(dropped), 0);

    // Overflow with a step landing in the push cycle.
    direction_pb = 4'b0100;
    tick();
    direction_pb = 4'b0000;
    tick();
    step = 1'b1;
    tick();
    step = 1'b0;
    chk("pushpop_count", int'(count), 4);
    chk("pushpop_no_drop", int'(dropped), 0);
    chk("pushpop_dir", int'(dir), 0);
    repeat (4) do_step();
    chk("drain_dir", int'(dir), 1);

    // Simultaneous buttons and a long hold.
    do_sync();
    press(4'b1001);
    chk("multi_count", int'(count), 1);
    do_step();
    chk("multi_dir", int'(dir), 0);
    do_sync();
    direction_pb = 4'b1000;
    tick(100);
    direction_pb = 4'b0000;
    tick(3);
    chk("hold_one_entry", int'(count), 1);

    // Sync together with step clears everything.
    do_sync();
    press(4'b1000);
    press(4'b0010);
    press(4'b0100);
    chk("presync_count", int'(count), 3);
    sync = 1'b1;
    step = 1'b1;
    tick();
    sync = 1'b0;
    step = 1'b0;
    chk("sync_step_count", int'(count), 0);
    chk("sync_step_dir", int'(dir), 3);

    // Asynchronous reset mid-queue.
    press(4'b1000);
    press(4'b0010);
    do_step();
    #3 nrst = 1'b0;
    #1;
    chk("areset_dir", int'(dir), 3);
    chk("areset_count", int'(count), 0);
    chk("areset_empty", int'(empty), 1);
    chk("areset_full", int'(full), 0);
    chk("areset_dropped", int'(dropped), 0);
    tick(2);
    nrst = 1'b1;
    press(4'b0100);
    chk("post_reset_push", int'(count), 1);
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/direction_queue.md
# direction_queue

Buffers player direction presses between the push-button inputs and the snake body controller, so that several quick turns made within one movement step are all applied on successive steps instead of only the last one surviving. The block synchronizes the raw button bus and detects rising edges. It filters redundant and illegal turns, holds accepted turns in a small FIFO, and releases one turn per movement-step pulse onto a registered current-direction output. It replaces the direct `{pb[10], pb[6], pb[5], pb[7]}` connection into the snake body controller.

## Interface
Parameters:
- `DEPTH`, default 4: FIFO entries; legal range 2–8.

Ports:
- `clk`, input, 1: system clock. One clock; all state is on its rising edge.
- `nrst`, input, 1: reset, asynchronous, active-low.
- `direction_pb`, input, 4: raw buttons, `[3]` up, `[2]` down, `[1]` left, `[0]` right.
- `step`, input, 1: one-cycle pulse when the snake advances one cell.
- `sync`, input, 1: synchronous game-restart clear.
- `dir`, output, 2: current direction. Encoding: `00` up, `01` down, `10` left, `11` right.
- `count`, output, `$clog2(DEPTH+1)`: entries held in the FIFO.
- `empty`, output, 1: `count == 0`.
- `full`, output, 1: `count == DEPTH`.
- `dropped`, output, 1: one-cycle pulse when a candidate turn is discarded because the FIFO is full.

## Operation
- **Input conditioning**
  - Each `direction_pb` bit passes through a 2-flop synchronizer, then a registered rising-edge detector.
  - Only rising edges generate candidates. A held button produces one candidate.
- **Candidate selection**
  - If several edges occur in the same cycle, one candidate is chosen by priority up > down > left > right.
  - The other edges in that cycle are discarded and are not flagged.
- **Reference direction**
  - The reference is the FIFO tail entry when `count > 0`, otherwise `dir`.
- **Filtering**
  - A candidate equal to the reference is discarded silently.
  - With `DIRQ_REVERSE_FILTER_EN` defined, a candidate equal to reference XOR `2'b01` (a 180° reversal) is also discarded silently.
- **Push**
  - A surviving candidate is written at the tail if the FIFO is not full.
  - If the FIFO is full and no pop occurs that cycle, the candidate is discarded and `dropped` pulses.
- **Pop**
  - On `step` with `count > 0`, the head entry is loaded into `dir` and removed.
  - On `step` with an empty FIFO, `dir` is held.
- **Simultaneous push and pop**
  - Both occur in the same cycle and `count` is unchanged.
  - When the FIFO is full, the pop frees the slot and the push is accepted; `dropped` stays 0.
  - Filtering uses the pre-cycle tail. If the pop removes the only entry, that entry was the tail and also becomes `dir`, so the reference stays consistent.
  - On an empty FIFO, the pop sees nothing; the pushed entry is applied on the next `step`.
- **Storage**: circular buffer with read and write pointers modulo `DEPTH`, plus an explicit counter. Pointers wrap from `DEPTH-1` to 0.
- **`sync`**
  - Effects: empties the FIFO (pointers and `count` to 0), sets `dir = 11` (right), clears `dropped`.
  - Synchronizer and edge-detector history are kept, so a button held across the restart does not enqueue.
  - `sync` has priority over `step` and push in the same cycle.

## Timing
- **Reset values**: `dir = 11`, `count = 0`, `empty = 1`, `full = 0`, `dropped = 0`. Synchronizer and edge history are all 0.
- **Press latency**
  - A press that is stable before rising edge k is captured by the synchronizer at edges k and k+1.
  - The edge is detected at k+2, with the push occurring at that edge.
  - `count` reflects the push after edge k+2.
- **Step latency**: `step` high at edge j gives the updated `dir` after edge j (registered, one cycle).
- **Output timing**
  - `count`, `empty` and `full` are registered or derived from registered state only.
  - `dropped` is registered and lasts exactly one cycle.
- **Reset mid-operation**: asserting `nrst` low clears everything immediately, independent of `clk`. Release is synchronous to the next edge.

## Configuration
- `DIRQ_REVERSE_FILTER_EN`
  - Defined: 180° reversals relative to the reference direction are discarded.
  - Undefined: reversals are enqueued like any other turn; the downstream collision logic then ends the game.

## Test plan
- Reset, then press up, no `step` → after 3 edges `count = 1`. Then `step` → `dir = 00`, `count = 0`.
- From `dir = 11`, press up, then left, then down within one step period → `count = 3`. Three `step` pulses give `dir` sequence 00, 10, 01.
- With `DIRQ_REVERSE_FILTER_EN` and `dir = 11`, press left → `count` stays 0, `dropped = 0`. Without the macro → `count = 1`.
- `DEPTH = 4`, enqueue 4 alternating turns, press a fifth → `dropped` pulses one cycle, `count = 4`. Repeat with `step` in the push cycle → accepted, `count = 4`, no `dropped`.
- Press up and right in the same cycle → only up is enqueued. Hold up for 100 cycles → exactly one entry.
- `count = 3`, assert `sync` together with `step` → `count = 0`, `dir = 11`. Assert `nrst` low mid-queue → all outputs at reset values.
